// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Consumed by debounce_ch and multi_ch_debounce_pulse.
package debounce_pkg;

    localparam int DEF_N_CH        = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 4;
    localparam int DEF_REPEAT_DLY  = 200;
    localparam int DEF_REPEAT_PER  = 50;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int rep_width(input int dly, input int per);
        return cnt_width((dly > per) ? dly : per);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, level, rise/fall pulses.
// With AUTO_REPEAT_EN defined, a hold counter re-fires rise_pulse while the level stays high.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_PER  = DEF_REPEAT_PER
) (
    input  logic clk_200H,
    input  logic rst_n,
    input  logic inp,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = cnt_width(STABLE_CNT);

    if (SYNC_STAGES < 2 || STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
        $error("debounce_ch: invalid parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   mismatch, accept;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], inp};
        mismatch = sync_q[SYNC_STAGES-1] ^ lvl_q;
        accept   = mismatch && (cnt_q == CW'(STABLE_CNT - 1));
        // Any cycle where the synced input agrees with the level restarts the window.
        if (!mismatch || accept) cnt_d = '0;
        else                     cnt_d = cnt_q + 1'b1;
        lvl_d  = lvl_q ^ accept;
        fall_d = accept & lvl_q;
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = rep_width(REPEAT_DLY, REPEAT_PER);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_arm_q, rep_arm_d;
    logic          rep_fire;

    // Hold counter starts the cycle after the level goes high; first fire
    // after REPEAT_DLY, then every REPEAT_PER once armed.
    always_comb begin
        rep_fire  = 1'b0;
        rep_cnt_d = '0;
        rep_arm_d = 1'b0;
        if (lvl_q && !accept) begin
            rep_fire  = rep_arm_q ? (rep_cnt_q == RW'(REPEAT_PER - 1))
                                  : (rep_cnt_q == RW'(REPEAT_DLY - 1));
            rep_cnt_d = rep_fire ? '0 : rep_cnt_q + 1'b1;
            rep_arm_d = rep_arm_q | rep_fire;
        end
        rise_d = (accept & ~lvl_q) | rep_fire;
    end

    always_ff @(posedge clk_200H) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    always_comb begin
        rise_d = accept & ~lvl_q;
    end
`endif

    always_ff @(posedge clk_200H) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_level   = lvl_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/multi_ch_debounce_pulse.sv
// N_CH independent debounce channels plus an OR-combined press pulse.
// Optional auto-repeat of rise pulses is enabled with the AUTO_REPEAT_EN macro.
module multi_ch_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_PER  = DEF_REPEAT_PER
) (
    input  logic            clk_200H,
    input  logic            rst_n,
    input  logic [N_CH-1:0] inp,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_PER  (REPEAT_PER)
        ) u_ch (
            .clk_200H   (clk_200H),
            .rst_n      (rst_n),
            .inp        (inp[i]),
            .db_level   (db_level[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    // Each rise_pulse bit is registered, so the OR is glitch-free in-cycle.
    assign any_pulse = |rise_pulse;

endmodule
